// File: rtl/link_partner_bridge.sv
// Remote link-cable partner: follows the Game Boy's serial clock in GB-master mode and generates
// the bit clock itself in GB-slave mode, exchanging whole bytes with a host over valid/ready.
//
// state  | meaning
// S_IDLE | waiting for SC armed (gb_start)
// S_MBIT | GB drives clock; shift on synchronised clock edges
// S_LOW  | we drive clock low; sample GB data on last cycle
// S_HIGH | we drive clock high; advance to next bit on last cycle
// S_GAP  | idle time after a generated byte so the CPU can re-arm SC
module link_partner_bridge #(
  parameter int CLK_DIV  = 511,
  parameter int TX_DEPTH = 4,
  parameter int GAP_CYC  = 1022
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gb_start,
  input  logic       gb_int_clock,
  input  logic       gb_clk_out,
  input  logic       gb_data_out,
  output logic       gb_clk_in,
  output logic       gb_data_in,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_ovf,
  input  logic       ovf_clr,
  output logic       busy
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = $clog2(TX_DEPTH);
  localparam logic [CW-1:0] DIV_LD = CW'(CLK_DIV);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYC - 1);
  localparam logic [PW:0]   DEPTH  = (PW + 1)'(TX_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_MBIT, S_LOW, S_HIGH, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          clk_in_q, clk_in_d;
  logic          data_in_q, data_in_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ovf_q, rx_ovf_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [7:0]    mem_q [TX_DEPTH];

  logic          fifo_empty, push, pop, deliver, fall_seen, rise_seen;
  logic [7:0]    tx_head;
  logic [CW-1:0] cnt_dec;

  assign fifo_empty = (count_q == '0);
  assign tx_ready   = (count_q != DEPTH);
  assign tx_head    = fifo_empty ? 8'hFF : mem_q[rd_ptr_q];
  assign push       = tx_valid & tx_ready;
  assign fall_seen  = sync_q[1] & ~sync_q[0];
  assign rise_seen  = ~sync_q[1] & sync_q[0];
  assign cnt_dec    = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[0], gb_clk_out};
    cnt_d      = cnt_q;
    bitcnt_d   = bitcnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    clk_in_d   = clk_in_q;
    data_in_d  = data_in_q;
    deliver    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gb_start && gb_int_clock) begin
          state_d    = S_MBIT;
          tx_shift_d = tx_head;
          bitcnt_d   = '0;
          data_in_d  = tx_head[7];
        end else if (gb_start && !gb_int_clock && !fifo_empty) begin
          state_d    = S_LOW;
          tx_shift_d = tx_head;
          bitcnt_d   = '0;
          clk_in_d   = 1'b0;
          data_in_d  = tx_head[7];
          cnt_d      = DIV_LD;
        end
      end
      S_MBIT: begin
        // Completion is checked before abort so a byte finished just as SC clears is kept.
        if (bitcnt_q == 4'd8) begin
          deliver = 1'b1;
          state_d = S_IDLE;
        end else if (!gb_start || !gb_int_clock) begin
          state_d   = S_IDLE;
          clk_in_d  = 1'b1;
          data_in_d = 1'b1;
        end else begin
          if (fall_seen) data_in_d = tx_shift_q[7];
          if (rise_seen) begin
            rx_shift_d = {rx_shift_q[6:0], gb_data_out};
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            bitcnt_d   = bitcnt_q + 4'd1;
          end
        end
      end
      S_LOW: begin
        if (!gb_start || gb_int_clock) begin
          state_d   = S_IDLE;
          clk_in_d  = 1'b1;
          data_in_d = 1'b1;
        end else if (cnt_q == '0) begin
          rx_shift_d = {rx_shift_q[6:0], gb_data_out};
          clk_in_d   = 1'b1;
          cnt_d      = DIV_LD;
          state_d    = S_HIGH;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_HIGH: begin
        if (!gb_start || gb_int_clock) begin
          state_d   = S_IDLE;
          clk_in_d  = 1'b1;
          data_in_d = 1'b1;
        end else if (cnt_q == '0) begin
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
          bitcnt_d   = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) begin
            deliver = 1'b1;
            cnt_d   = GAP_LD;
            state_d = S_GAP;
          end else begin
            clk_in_d  = 1'b0;
            data_in_d = tx_shift_q[6];
            cnt_d     = DIV_LD;
            state_d   = S_LOW;
          end
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_dec;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pop = deliver & ~fifo_empty;

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_ovf_d   = ovf_clr ? 1'b0 : rx_ovf_q;
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        rx_ovf_d = 1'b1;
      end
    end else if (rx_ready && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sync_q     <= 2'b11;
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      clk_in_q   <= 1'b1;
      data_in_q  <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovf_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      clk_in_q   <= clk_in_d;
      data_in_q  <= data_in_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovf_q   <= rx_ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  assign gb_clk_in  = clk_in_q;
  assign gb_data_in = data_in_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_ovf     = rx_ovf_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_link_partner_bridge.sv
// Directed bench for link_partner_bridge: slave generation, master follow, empty FIFO,
// overflow, abort and mid-byte reset, each with hand-computed expectations.
module tb_link_partner_bridge;
  localparam int CLK_DIV = 3, TX_DEPTH = 4, GAP_CYC = 6;

  logic clk = 1'b0, rst = 1'b1;
  logic gb_start = 0, gb_int_clock = 0, gb_clk_out = 1, gb_data_out = 1;
  logic gb_clk_in, gb_data_in, tx_ready, rx_valid, rx_ovf, busy;
  logic [7:0] tx_data = 0, rx_data;
  logic tx_valid = 0, rx_ready = 0, ovf_clr = 0;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  link_partner_bridge #(.CLK_DIV(CLK_DIV), .TX_DEPTH(TX_DEPTH), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst(rst), .gb_start(gb_start), .gb_int_clock(gb_int_clock),
    .gb_clk_out(gb_clk_out), .gb_data_out(gb_data_out), .gb_clk_in(gb_clk_in),
    .gb_data_in(gb_data_in), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_ovf(rx_ovf),
    .ovf_clr(ovf_clr), .busy(busy));

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] d);
    tx_data = d; tx_valid = 1; cyc(); tx_valid = 0;
  endtask

  task automatic consume();
    rx_ready = 1; cyc(); rx_ready = 0;
  endtask

  // GB as clock master: 8-cycle half periods, data out on fall, sample gb_data_in at rise.
  task automatic master_xfer(input logic [7:0] gb_tx, output logic [7:0] gb_rx);
    logic [7:0] sh;
    sh = gb_tx; gb_rx = 8'h00;
    gb_int_clock = 1; gb_start = 1;
    repeat (3) cyc();
    for (int i = 0; i < 8; i++) begin
      gb_clk_out = 0; gb_data_out = sh[7]; sh = {sh[6:0], 1'b0};
      repeat (8) cyc();
      gb_rx = {gb_rx[6:0], gb_data_in};
      gb_clk_out = 1;
      repeat (8) cyc();
    end
    gb_start = 0;
    repeat (2) cyc();
  endtask

  task automatic test_reset();
    repeat (3) cyc();
    compared++; if (gb_clk_in !== 1'b1) begin mismatched++; $display("FAIL reset_clk_in: got %b expected 1", gb_clk_in); end
    compared++; if (gb_data_in !== 1'b1) begin mismatched++; $display("FAIL reset_data_in: got %b expected 1", gb_data_in); end
    compared++; if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    compared++; if (rx_data !== 8'h00) begin mismatched++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    compared++; if (rx_ovf !== 1'b0) begin mismatched++; $display("FAIL reset_rx_ovf: got %b expected 0", rx_ovf); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
    compared++; if (tx_ready !== 1'b1) begin mismatched++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
    rst = 0;
    cyc();
  endtask

  task automatic test_slave();
    logic [7:0] sh, got;
    logic prev;
    int n, last, nfall, nrise, bad_low, bad_high;
    push(8'hA5);
    sh = 8'h3C; got = 0; prev = 1; n = 0; last = 0; nfall = 0; nrise = 0; bad_low = 0; bad_high = 0;
    gb_int_clock = 0; gb_start = 1;
    while (!rx_valid && n < 300) begin
      cyc(); n++;
      if (prev && !gb_clk_in) begin
        if (nfall > 0 && n - last != CLK_DIV + 1) bad_high++;
        last = n; nfall++;
        gb_data_out = sh[7]; sh = {sh[6:0], 1'b0};
      end else if (!prev && gb_clk_in) begin
        if (n - last != CLK_DIV + 1) bad_low++;
        last = n; nrise++;
        got = {got[6:0], gb_data_in};
      end
      prev = gb_clk_in;
    end
    compared++; if (rx_valid !== 1'b1) begin mismatched++; $display("FAIL slave_done: rx_valid %b expected 1 within 300 cycles", rx_valid); end
    compared++; if (nfall != 8 || nrise != 8) begin mismatched++; $display("FAIL slave_edges: got %0d falls %0d rises expected 8 8", nfall, nrise); end
    compared++; if (bad_low != 0 || bad_high != 0) begin mismatched++; $display("FAIL slave_phase_len: %0d bad lows %0d bad highs expected 0 0", bad_low, bad_high); end
    compared++; if (n - last != CLK_DIV + 1) begin mismatched++; $display("FAIL slave_last_high: got %0d cycles expected 4", n - last); end
    compared++; if (got !== 8'hA5) begin mismatched++; $display("FAIL slave_gb_rx: got %h expected a5", got); end
    compared++; if (rx_data !== 8'h3C) begin mismatched++; $display("FAIL slave_rx_data: got %h expected 3c", rx_data); end
    // FIFO now empty: with gb_start still armed the bridge must settle in IDLE after the gap.
    repeat (GAP_CYC + 4) cyc();
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL slave_fifo_empty: busy %b expected 0", busy); end
    gb_start = 0;
    consume();
    compared++; if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL slave_consume: rx_valid %b expected 0", rx_valid); end
  endtask

  task automatic test_master();
    logic [7:0] r;
    push(8'h5A);
    master_xfer(8'h81, r);
    compared++; if (r !== 8'h5A) begin mismatched++; $display("FAIL master_gb_rx: got %h expected 5a", r); end
    compared++; if (rx_data !== 8'h81 || rx_valid !== 1'b1) begin mismatched++; $display("FAIL master_rx: got %h/%b expected 81/1", rx_data, rx_valid); end
    consume();
  endtask

  task automatic test_empty_master();
    logic [7:0] r;
    master_xfer(8'h42, r);
    compared++; if (r !== 8'hFF) begin mismatched++; $display("FAIL empty_gb_rx: got %h expected ff", r); end
    compared++; if (rx_data !== 8'h42) begin mismatched++; $display("FAIL empty_rx_data: got %h expected 42", rx_data); end
    push(8'h11); push(8'h22); push(8'h33);
    compared++; if (tx_ready !== 1'b1) begin mismatched++; $display("FAIL empty_count3: tx_ready %b expected 1", tx_ready); end
    push(8'h44);
    compared++; if (tx_ready !== 1'b0) begin mismatched++; $display("FAIL empty_count4: tx_ready %b expected 0", tx_ready); end
    consume();
  endtask

  task automatic test_overflow();
    logic [7:0] r1, r2;
    master_xfer(8'h96, r1);
    master_xfer(8'h69, r2);
    compared++; if (r1 !== 8'h11 || r2 !== 8'h22) begin mismatched++; $display("FAIL ovf_gb_rx: got %h %h expected 11 22", r1, r2); end
    compared++; if (rx_data !== 8'h96 || rx_valid !== 1'b1) begin mismatched++; $display("FAIL ovf_rx_keep: got %h/%b expected 96/1", rx_data, rx_valid); end
    compared++; if (rx_ovf !== 1'b1) begin mismatched++; $display("FAIL ovf_set: got %b expected 1", rx_ovf); end
    ovf_clr = 1; cyc(); ovf_clr = 0;
    compared++; if (rx_ovf !== 1'b0) begin mismatched++; $display("FAIL ovf_clr: got %b expected 0", rx_ovf); end
  endtask

  task automatic test_abort();
    logic prev;
    int n, nrise;
    prev = 1; n = 0; nrise = 0;
    gb_int_clock = 0; gb_start = 1;
    while (nrise < 3 && n < 200) begin
      cyc(); n++;
      if (!prev && gb_clk_in) nrise++;
      prev = gb_clk_in;
    end
    compared++; if (nrise != 3) begin mismatched++; $display("FAIL abort_reach: got %0d rises expected 3", nrise); end
    repeat (2) cyc();
    gb_start = 0;
    cyc();
    compared++; if (busy !== 1'b0 || gb_clk_in !== 1'b1 || gb_data_in !== 1'b1) begin mismatched++; $display("FAIL abort_idle: busy/clk/data %b%b%b expected 011", busy, gb_clk_in, gb_data_in); end
    compared++; if (rx_valid !== 1'b1 || rx_data !== 8'h96) begin mismatched++; $display("FAIL abort_rx_unchanged: got %h/%b expected 96/1", rx_data, rx_valid); end
    push(8'h55);
    compared++; if (tx_ready !== 1'b1) begin mismatched++; $display("FAIL abort_count3: tx_ready %b expected 1", tx_ready); end
    push(8'h66);
    compared++; if (tx_ready !== 1'b0) begin mismatched++; $display("FAIL abort_count4: tx_ready %b expected 0", tx_ready); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    gb_int_clock = 0; gb_start = 1;
    repeat (10) cyc();
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL rstmid_busy: got %b expected 1", busy); end
    rst = 1; gb_start = 0;
    cyc();
    compared++; if (gb_clk_in !== 1'b1 || gb_data_in !== 1'b1 || busy !== 1'b0) begin mismatched++; $display("FAIL rstmid_pins: clk/data/busy %b%b%b expected 110", gb_clk_in, gb_data_in, busy); end
    compared++; if (rx_valid !== 1'b0 || rx_data !== 8'h00 || rx_ovf !== 1'b0) begin mismatched++; $display("FAIL rstmid_rx: %h/%b/%b expected 00/0/0", rx_data, rx_valid, rx_ovf); end
    compared++; if (tx_ready !== 1'b1) begin mismatched++; $display("FAIL rstmid_tx_ready: got %b expected 1", tx_ready); end
    rst = 0;
    cyc();
    push(8'hA1); push(8'hA2); push(8'hA3);
    compared++; if (tx_ready !== 1'b1) begin mismatched++; $display("FAIL fill_count3: tx_ready %b expected 1", tx_ready); end
    push(8'hA4);
    compared++; if (tx_ready !== 1'b0) begin mismatched++; $display("FAIL fill_full: tx_ready %b expected 0", tx_ready); end
    tx_data = 8'hB5; tx_valid = 1;
    master_xfer(8'h00, r);
    tx_valid = 0;
    compared++; if (r !== 8'hA1) begin mismatched++; $display("FAIL full_pop_head: got %h expected a1", r); end
    compared++; if (tx_ready !== 1'b0) begin mismatched++; $display("FAIL full_refill: tx_ready %b expected 0", tx_ready); end
    compared++; if (rx_data !== 8'h00 || rx_valid !== 1'b1) begin mismatched++; $display("FAIL full_rx: got %h/%b expected 00/1", rx_data, rx_valid); end
  endtask

  initial begin
    test_reset();
    test_slave();
    test_master();
    test_empty_master();
    test_overflow();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
